cluster_lister: RTL and testbench
=================================

Name: cluster_lister

Overview:
- Iterative cluster extractor that sits directly upstream of the 1536-input priority encoder and closes the loop around it.
- Captures one event's VPF vector and presents the masked vector to the encoder. For each valid hit it reads back the encoder address, stores it, and clears that bit.
- Repeats until the vector is empty or MXCLUSTERS addresses have been collected, then publishes the list to the downstream cluster packer.

Parameters:
- MXKEYS, 1536, width of VPF vector.
- MXADRBITS, 11, encoder address width.
- MXCLUSTERS, 8, maximum clusters listed per event.
- ENC_LATENCY, 1, encoder register stages between enc_vpfs and enc_adr.
- NULL_ADR, 11'h7FE, encoder "no hit" code and empty-slot fill value.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- vpfs  in  MXKEYS  event VPF vector, sampled on load.
- load  in  1  start strobe; accepted only when busy=0.
- busy  out  1  high from accepted load until the cycle done is asserted.
- enc_vpfs  out  MXKEYS  masked working vector, driven to the encoder vpfs input (registered).
- enc_adr  in  MXADRBITS  encoder address output.
- clust_adr  out  MXCLUSTERS*MXADRBITS  slot i at bits [i*11+10 : i*11].
- clust_cnt  out  4  number of valid slots, 0..MXCLUSTERS.
- overflow  out  1  hits remained after MXCLUSTERS were listed.
- done  out  1  one-cycle pulse when the list is final.
- err  out  1  encoder consistency error (optional feature).

Behaviour:
- Reset (async assert, sync release): state IDLE.
  - enc_vpfs = 0.
  - clust_adr = all slots NULL_ADR.
  - clust_cnt = 0, overflow = 0, done = 0, busy = 0, err = 0.
- States: IDLE, WAIT, SAMPLE, FINISH.
- IDLE:
  - load=1 → enc_vpfs <= vpfs.
  - All slots <= NULL_ADR; clust_cnt, overflow and err <= 0.
  - busy <= 1; wait counter <= 0; go WAIT.
- WAIT: counter increments each cycle. When counter reaches ENC_LATENCY, go SAMPLE.
  - Result: enc_adr is sampled ENC_LATENCY+1 edges after the last enc_vpfs update.
- SAMPLE: let a = enc_adr.
  - If a == NULL_ADR or a >= MXKEYS → FINISH.
  - Otherwise:
    - slot[clust_cnt] <= a.
    - enc_vpfs[a] <= 0.
    - clust_cnt <= clust_cnt+1.
  - If clust_cnt+1 == MXCLUSTERS:
    - overflow <= |(enc_vpfs with bit a cleared).
    - Go FINISH.
  - Else reset counter; go WAIT.
- FINISH: done=1 for exactly one cycle; busy <= 0; go IDLE.
  - clust_adr, clust_cnt and overflow hold until the next accepted load.
  - enc_vpfs holds its final residue.
- Cycle cost per event: (k+1)*(ENC_LATENCY+2)+1 cycles, where k = clusters found and k < MXCLUSTERS. With ENC_LATENCY=1: 3 cycles per iteration.
- Ordering: addresses appear in ascending order, because the encoder gives priority to the lowest index.
- Boundaries:
  - load while busy is ignored; no queueing.
  - load in the same cycle as done is ignored; busy is still 1 that cycle.
  - Empty vector → done after ENC_LATENCY+3 cycles, clust_cnt=0.
  - Exactly MXCLUSTERS hits → overflow=0. MXCLUSTERS+1 hits → overflow=1.
  - reset mid-event aborts immediately, clears all outputs, and emits no done.

Optional Feature:
- Macro: CLUSTER_LISTER_CHECK_EN.
- Defined:
  - In SAMPLE, when a < MXKEYS and enc_vpfs[a]==0, set err. This indicates a stale or incorrect encoder result.
  - Also set err when a is neither NULL_ADR nor < MXKEYS.
  - Also set err when a is not strictly greater than the previous listed address.
  - err is sticky until the next accepted load. Listing behaviour is unchanged.
- Undefined: err is tied to 0 and no checking logic is built.

Test Plan:
- vpfs bits {5, 700, 1535} set, load → done with clust_cnt=3; slots 5, 700, 1535, then NULL_ADR ×5; overflow=0; done 13 cycles after load.
- vpfs=0, load → done 4 cycles after load; clust_cnt=0; all slots 11'h7FE; overflow=0.
- vpfs bits 0..9 set → clust_cnt=8; slots 0..7; overflow=1; enc_vpfs residue has only bits 8 and 9 set.
- load again 2 cycles after the first load → ignored; result matches the first vector only.
- Assert reset low mid-WAIT after 2 clusters → all outputs at reset values; no done pulse. A following load of bit 42 yields clust_cnt=1, slot0=42.
- With CLUSTER_LISTER_CHECK_EN, stub the encoder to return 3 while bit 3 is clear → err=1 until the next load. Without the macro → err stays 0.

Source files
------------

// File: rtl/cluster_lister.sv
// Iterative cluster extractor wrapped around the 1536-input priority encoder.
// Define CLUSTER_LISTER_CHECK_EN to build the encoder consistency checker that drives err.
module cluster_lister #(
    parameter int                   MXKEYS      = 1536,
    parameter int                   MXADRBITS   = 11,
    parameter int                   MXCLUSTERS  = 8,
    parameter int                   ENC_LATENCY = 1,
    parameter logic [MXADRBITS-1:0] NULL_ADR    = 11'h7FE
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [MXKEYS-1:0]               vpfs,
    input  logic                            load,
    output logic                            busy,
    output logic [MXKEYS-1:0]               enc_vpfs,
    input  logic [MXADRBITS-1:0]            enc_adr,
    output logic [MXCLUSTERS*MXADRBITS-1:0] clust_adr,
    output logic [3:0]                      clust_cnt,
    output logic                            overflow,
    output logic                            done,
    output logic                            err
);

    localparam int CNTW  = (ENC_LATENCY < 1) ? 1 : $clog2(ENC_LATENCY + 1);
    localparam int SLOTW = (MXCLUSTERS < 2) ? 1 : $clog2(MXCLUSTERS);
    localparam logic [CNTW-1:0]    LAT      = CNTW'(ENC_LATENCY);
    localparam logic [3:0]         LAST_CNT = 4'(MXCLUSTERS - 1);
    localparam logic [MXADRBITS:0] KEYS_LIM = (MXADRBITS + 1)'(MXKEYS);

    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, FINISH} state_e;

    state_e                 state_q, state_d;
    logic [CNTW-1:0]        wait_q, wait_d;
    logic [MXKEYS-1:0]      vec_q, vec_d;
    logic [MXADRBITS-1:0]   slot_q [MXCLUSTERS];
    logic [MXADRBITS-1:0]   slot_d [MXCLUSTERS];
    logic [3:0]             cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   in_range;
    logic                   hit;
    logic [MXKEYS-1:0]      cleared;

    assign in_range = ({1'b0, enc_adr} < KEYS_LIM);
    assign hit      = in_range && (enc_adr != NULL_ADR);
    assign cleared  = vec_q & ~(MXKEYS'(1) << enc_adr);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
            vec_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < MXCLUSTERS; i++) slot_q[i] <= NULL_ADR;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < MXCLUSTERS; i++) slot_q[i] <= slot_d[i];
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        for (int i = 0; i < MXCLUSTERS; i++) slot_d[i] = slot_q[i];
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    vec_d  = vpfs;
                    cnt_d  = '0;
                    ovf_d  = 1'b0;
                    wait_d = '0;
                    for (int i = 0; i < MXCLUSTERS; i++) slot_d[i] = NULL_ADR;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (wait_q == LAT) state_d = SAMPLE;
                else               wait_d  = wait_q + 1'b1;
            end
            SAMPLE: begin
                if (!hit) begin
                    state_d = FINISH;
                end else begin
                    slot_d[cnt_q[SLOTW-1:0]] = enc_adr;
                    vec_d = cleared;
                    cnt_d = cnt_q + 4'd1;
                    // Full list: whatever is left in the vector is reported as overflow.
                    if (cnt_q == LAST_CNT) begin
                        ovf_d   = |cleared;
                        state_d = FINISH;
                    end else begin
                        wait_d  = '0;
                        state_d = WAIT;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == FINISH);
    end

    for (genvar g = 0; g < MXCLUSTERS; g++) begin : g_pack
        assign clust_adr[g*MXADRBITS +: MXADRBITS] = slot_q[g];
    end

    assign enc_vpfs  = vec_q;
    assign clust_cnt = cnt_q;
    assign overflow  = ovf_q;

`ifdef CLUSTER_LISTER_CHECK_EN
    logic                 err_q, err_d;
    logic [MXADRBITS-1:0] prev_adr;

    assign prev_adr = slot_q[SLOTW'(cnt_q - 4'd1)];

    // Flags stale, out-of-range or non-ascending encoder answers; sticky until the next load.
    always_comb begin
        err_d = err_q;
        if (state_q == IDLE && load) begin
            err_d = 1'b0;
        end else if (state_q == SAMPLE) begin
            if (in_range && !vec_q[enc_adr])                    err_d = 1'b1;
            if (!in_range && enc_adr != NULL_ADR)               err_d = 1'b1;
            if (in_range && cnt_q != 4'd0 && enc_adr <= prev_adr) err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cluster_lister.sv
// Directed bench for cluster_lister with a registered lowest-index priority encoder model.
// The encoder can be forced to a fixed address to provoke the optional consistency checker.
module tb_cluster_lister;

    localparam logic [10:0] NULL_ADR  = 11'h7FE;
    localparam logic [87:0] NULL_LIST = {8{11'h7FE}};
`ifdef CLUSTER_LISTER_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic          clock;
    logic          reset;
    logic [1535:0] vpfs;
    logic          load;
    logic          busy;
    logic [1535:0] encVpfs;
    logic [10:0]   encAdr = 11'h7FE;
    logic [87:0]   clustAdr;
    logic [3:0]    clustCnt;
    logic          overflow;
    logic          done;
    logic          err;
    logic          stubEnc;

    int checkCount = 0;
    int passCount  = 0;
    int expAdr [8];

    cluster_lister dut (
        .clock     (clock),
        .reset     (reset),
        .vpfs      (vpfs),
        .load      (load),
        .busy      (busy),
        .enc_vpfs  (encVpfs),
        .enc_adr   (encAdr),
        .clust_adr (clustAdr),
        .clust_cnt (clustCnt),
        .overflow  (overflow),
        .done      (done),
        .err       (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [10:0] prioEnc(input logic [1535:0] v);
        for (int i = 0; i < 1536; i++) if (v[i]) return 11'(i);
        return NULL_ADR;
    endfunction

    // One register stage between enc_vpfs and enc_adr.
    always @(posedge clock) encAdr <= stubEnc ? 11'd3 : prioEnc(encVpfs);

    task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [1535:0] vec);
        @(negedge clock);
        vpfs = vec;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic waitDone(input int startCycle, input int limit, output int cyc);
        cyc = startCycle;
        while (!done && cyc < limit) begin
            @(negedge clock);
            cyc++;
        end
        checkOutput("done seen", 96'(done), 96'(1));
    endtask

    task automatic checkList(input string tag, input int n, input logic ovf);
        checkOutput({tag, " cnt"}, 96'(clustCnt), 96'(n));
        checkOutput({tag, " ovf"}, 96'(overflow), 96'(ovf));
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("%s slot%0d", tag, i), 96'(clustAdr[i*11 +: 11]),
                        96'((i < n) ? expAdr[i] : 32'h7FE));
    endtask

    initial begin
        $display("[TB] watchdog armed");
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1535:0] vec;
        int            cyc;
        int            doneSeen;

        reset   = 1'b0;
        load    = 1'b0;
        vpfs    = '0;
        stubEnc = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("reset busy", 96'(busy), 96'(0));
        checkOutput("reset done", 96'(done), 96'(0));
        checkOutput("reset cnt", 96'(clustCnt), 96'(0));
        checkOutput("reset ovf", 96'(overflow), 96'(0));
        checkOutput("reset err", 96'(err), 96'(0));
        checkOutput("reset encvpfs", 96'(|encVpfs), 96'(0));
        checkOutput("reset slots", 96'(clustAdr), 96'(NULL_LIST));
        reset = 1'b1;

        // Three scattered hits, including the top key
        vec = '0; vec[5] = 1'b1; vec[700] = 1'b1; vec[1535] = 1'b1;
        applyStimulus(vec);
        checkOutput("t1 busy", 96'(busy), 96'(1));
        waitDone(1, 60, cyc);
        checkOutput("t1 latency", 96'(cyc), 96'(13));
        checkOutput("t1 busy at done", 96'(busy), 96'(1));
        expAdr = '{5, 700, 1535, 0, 0, 0, 0, 0};
        checkList("t1", 3, 1'b0);

        // A load coinciding with done must be dropped
        vec = '0; vec[9] = 1'b1;
        vpfs = vec;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        checkOutput("done-load busy", 96'(busy), 96'(0));
        checkOutput("done-load cnt", 96'(clustCnt), 96'(3));
        checkOutput("done-load slot0", 96'(clustAdr[10:0]), 96'(5));

        applyStimulus('0);
        waitDone(1, 60, cyc);
        checkOutput("t2 latency", 96'(cyc), 96'(4));
        checkList("t2", 0, 1'b0);

        vec = '0;
        for (int i = 0; i < 10; i++) vec[i] = 1'b1;
        applyStimulus(vec);
        waitDone(1, 100, cyc);
        checkOutput("t3 latency", 96'(cyc), 96'(25));
        expAdr = '{0, 1, 2, 3, 4, 5, 6, 7};
        checkList("t3", 8, 1'b1);
        checkOutput("t3 residue low", 96'(encVpfs[15:0]), 96'(16'h0300));
        checkOutput("t3 residue bits", 96'($countones(encVpfs)), 96'(2));

        vec = '0;
        for (int i = 0; i < 8; i++) vec[100 + 3*i] = 1'b1;
        applyStimulus(vec);
        waitDone(1, 100, cyc);
        expAdr = '{100, 103, 106, 109, 112, 115, 118, 121};
        checkList("t4", 8, 1'b0);

        // Second load while busy is ignored
        vec = '0; vec[1] = 1'b1; vec[2] = 1'b1;
        applyStimulus(vec);
        vec = '0; vec[100] = 1'b1;
        applyStimulus(vec);
        waitDone(3, 60, cyc);
        checkOutput("t5 latency", 96'(cyc), 96'(10));
        expAdr = '{1, 2, 0, 0, 0, 0, 0, 0};
        checkList("t5", 2, 1'b0);

        // Reset during the WAIT that follows the second listed cluster
        vec = '0; vec[10] = 1'b1; vec[20] = 1'b1; vec[30] = 1'b1;
        applyStimulus(vec);
        repeat (6) @(negedge clock);
        checkOutput("t6 mid cnt", 96'(clustCnt), 96'(2));
        reset = 1'b0;
        #1;
        checkOutput("t6 busy", 96'(busy), 96'(0));
        checkOutput("t6 cnt", 96'(clustCnt), 96'(0));
        checkOutput("t6 slots", 96'(clustAdr), 96'(NULL_LIST));
        checkOutput("t6 encvpfs", 96'(|encVpfs), 96'(0));
        checkOutput("t6 ovf", 96'(overflow), 96'(0));
        doneSeen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (done) doneSeen++;
        end
        checkOutput("t6 no done", 96'(doneSeen), 96'(0));
        reset = 1'b1;
        vec = '0; vec[42] = 1'b1;
        applyStimulus(vec);
        waitDone(1, 60, cyc);
        checkOutput("t6 latency", 96'(cyc), 96'(7));
        expAdr = '{42, 0, 0, 0, 0, 0, 0, 0};
        checkList("t6", 1, 1'b0);

        // Encoder stuck at 3 while bit 3 is clear
        stubEnc = 1'b1;
        vec = '0; vec[7] = 1'b1;
        applyStimulus(vec);
        waitDone(1, 100, cyc);
        expAdr = '{3, 3, 3, 3, 3, 3, 3, 3};
        checkList("t7", 8, 1'b1);
        checkOutput("t7 err", 96'(err), 96'(EXP_ERR));
        repeat (3) @(negedge clock);
        checkOutput("t7 err sticky", 96'(err), 96'(EXP_ERR));
        stubEnc = 1'b0;
        vec = '0; vec[1] = 1'b1;
        applyStimulus(vec);
        checkOutput("t7 err cleared", 96'(err), 96'(0));
        waitDone(1, 60, cyc);
        checkOutput("t7 clean cnt", 96'(clustCnt), 96'(1));
        checkOutput("t7 clean err", 96'(err), 96'(0));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
